// File: rtl/leb128_dec_stream_ctrl_if.sv
// leb128_dec_stream_ctrl_if
//   Byte-stream input and decoded-value output of the LEB128 stream decoder.
//   Signals:
//     in_data[7:0]   encoded byte (bit7 = continuation, bits6:0 = payload)
//     in_signed      decode mode, taken with the first byte of each value
//     in_valid       producer offers in_data
//     in_ready       decoder accepts in_data
//     out_data[31:0] decoded value (zero on error)
//     out_err        value was malformed
//     out_valid      result offered, held until accepted
//     out_ready      consumer accepts the result
//   Modports: slave = decoder side, master = producer/consumer side.
interface leb128_dec_stream_ctrl_if;
  logic [7:0]  in_data;
  logic        in_signed;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_data, in_signed, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

  modport master (
    output in_data, in_signed, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/leb128_dec_stream_ctrl.sv
// leb128_dec_stream_ctrl
//   Collects 1..5 LEB128 bytes of a 32-bit value from a byte stream, decodes
//   them (signed or unsigned, chosen with the first byte), and offers the
//   result on a valid/ready output. Overlong encodings report an error and
//   the remainder of the bad value is drained before decoding resumes.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        leb128_dec_stream_ctrl_if.slave (byte input, result output)
//     dbg_state  current FSM state (0 COLLECT, 1 EMIT, 2 DRAIN)
//   Optional build macro:
//     LEB128_DEC_OVERFLOW_CHK_EN  reject a terminating 5th byte whose
//                                 payload bits 6:4 do not fit 32 bits.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. A producer holds its data stable while valid = 1 and ready = 0;
// out_valid/out_data/out_err stay put until out_ready is seen.
module leb128_dec_stream_ctrl #(
  parameter int MAX_BYTES = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  leb128_dec_stream_ctrl_if.slave       bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  win_q [MAX_BYTES];
  logic [6:0]  win_d [MAX_BYTES];
  logic        mode_q, mode_d;
  logic        drain_q, drain_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        rst_done_q;

  logic        in_ready_c;
  logic        fire;
  logic [2:0]  cnt_use;
  logic        mode_eff;
  logic [6:0]  pl [MAX_BYTES];
  logic [34:0] raw;
  logic [31:0] dec_val;
  logic        ovf;
  logic        coll;

  // Signed decode: sign bit is bit6 of the terminating byte; a 5-byte value
  // already fills all 32 bits, so it is simply truncated.
  function automatic logic [31:0] unpack_i32(input logic [34:0] r, input logic [2:0] n);
    logic [31:0] v;
    case (n)
      3'd0:    v = {{25{r[6]}},  r[6:0]};
      3'd1:    v = {{18{r[13]}}, r[13:0]};
      3'd2:    v = {{11{r[20]}}, r[20:0]};
      3'd3:    v = {{4{r[27]}},  r[27:0]};
      default: v = r[31:0];
    endcase
    return v;
  endfunction

  function automatic logic [31:0] unpack_u32(input logic [34:0] r);
    return r[31:0];
  endfunction

  // The byte being accepted lands at index cnt_use. Leaving EMIT restarts a
  // value, so a byte taken in that cycle is the first byte of the next value.
  assign cnt_use  = (state_q == COLLECT) ? cnt_q : 3'd0;
  assign mode_eff = (cnt_use == 3'd0) ? bus.in_signed : mode_q;

  // In EMIT the input is ready exactly when the result leaves (bypass).
  // rst_done_q holds input off until the first clock after reset release.
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      COLLECT: in_ready_c = rst_done_q;
      EMIT:    in_ready_c = rst_done_q & bus.out_ready;
      DRAIN:   in_ready_c = rst_done_q;
      default: in_ready_c = 1'b0;
    endcase
  end

  assign fire = bus.in_valid & in_ready_c;

  // Decoder window: stored payloads below the current byte, the incoming
  // payload at its slot, zero above it.
  always_comb begin
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (3'(i) < cnt_use)       pl[i] = win_q[i];
      else if (3'(i) == cnt_use) pl[i] = bus.in_data[6:0];
      else                       pl[i] = 7'd0;
    end
  end

  assign raw     = {pl[4], pl[3], pl[2], pl[1], pl[0]};
  assign dec_val = mode_eff ? unpack_i32(raw, cnt_use) : unpack_u32(raw);

`ifdef LEB128_DEC_OVERFLOW_CHK_EN
  // Bits above 31 carried by the 5th byte must be pure zero/sign extension.
  always_comb begin
    ovf = 1'b0;
    if (cnt_use == 3'(MAX_BYTES - 1)) begin
      if (mode_eff) ovf = (bus.in_data[6:4] != {3{bus.in_data[3]}});
      else          ovf = (bus.in_data[6:4] != 3'd0);
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^raw[34:32];
  assign ovf       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    mode_d  = mode_q;
    drain_d = drain_q;
    data_d  = data_q;
    err_d   = err_q;
    coll    = 1'b0;

    case (state_q)
      COLLECT: coll = fire;
      EMIT: begin
        if (bus.out_ready) begin
          for (int i = 0; i < MAX_BYTES; i++) win_d[i] = 7'd0;
          cnt_d = 3'd0;
          if (drain_q) begin
            drain_d = 1'b0;
            state_d = (fire && !bus.in_data[7]) ? COLLECT : DRAIN;
          end else begin
            state_d = COLLECT;
            coll    = fire;
          end
        end
      end
      DRAIN: begin
        if (fire && !bus.in_data[7]) begin
          state_d = COLLECT;
          cnt_d   = 3'd0;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (coll) begin
      if (cnt_use == 3'd0) mode_d = bus.in_signed;
      if (!bus.in_data[7]) begin
        data_d  = ovf ? 32'd0 : dec_val;
        err_d   = ovf;
        cnt_d   = 3'd0;
        state_d = EMIT;
      end else if (cnt_use == 3'(MAX_BYTES - 1)) begin
        // Still continuing on the last legal byte: overlong.
        data_d  = 32'd0;
        err_d   = 1'b1;
        drain_d = 1'b1;
        cnt_d   = 3'd0;
        state_d = EMIT;
      end else begin
        win_d[cnt_use] = bus.in_data[6:0];
        cnt_d          = cnt_use + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= 3'd0;
      for (int i = 0; i < MAX_BYTES; i++) win_q[i] <= 7'd0;
      mode_q     <= 1'b0;
      drain_q    <= 1'b0;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      mode_q     <= mode_d;
      drain_q    <= drain_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rst_done_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_leb128_dec_stream_ctrl.sv
module tb_leb128_dec_stream_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  leb128_dec_stream_ctrl_if bus();

  leb128_dec_stream_ctrl #(.MAX_BYTES(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output got err=%b data=%h", bus.out_err, bus.out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({bus.out_err, bus.out_data} !== e) begin
          n_bad++;
          $display("FAIL result got err=%b data=%h expected err=%b data=%h",
                   bus.out_err, bus.out_data, e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic s);
    int n = 0;
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout byte=%h in_ready=%b expected=1", d, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_seq(input logic [7:0] b[5], input int n, input logic s);
    for (int i = 0; i < n; i++) send_byte(b[i], s);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reference encoder (minimal-length LEB128).
  function automatic int encode(input logic [31:0] v, input logic s, output logic [7:0] b[5]);
    int n = 0;
    logic done = 1'b0;
    logic signed [31:0] sv;
    logic [6:0] p;
    sv = v;
    for (int i = 0; i < 5; i++) b[i] = 8'h00;
    while (!done) begin
      p = sv[6:0];
      if (s) begin
        sv   = sv >>> 7;
        done = (sv == 0 && !p[6]) || (sv == -1 && p[6]);
      end else begin
        sv   = $signed($unsigned(sv) >> 7);
        done = (sv == 0);
      end
      b[n] = {~done, p};
      n++;
    end
    return n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b[5];
    int          n;
    logic        sgn;
    logic [31:0] d;
    logic        e;
  } vec_t;

  vec_t tbl[12];

  task automatic set_vec(input int idx, input logic [39:0] bytes, input int n,
                         input logic s, input logic [31:0] d, input logic e);
    for (int i = 0; i < 5; i++) tbl[idx].b[i] = bytes[39 - 8*i -: 8];
    tbl[idx].n   = n;
    tbl[idx].sgn = s;
    tbl[idx].d   = d;
    tbl[idx].e   = e;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  rb[5];
    logic [31:0] rv;
    logic        rs;
    int          rn;
    int          w;
    logic [7:0]  ob[5];

    set_vec(0,  40'hE5_8E_26_00_00, 3, 1'b0, 32'h0009_8765, 1'b0);
    set_vec(1,  40'hC0_BB_78_00_00, 3, 1'b1, 32'hFFFE_1DC0, 1'b0);
    set_vec(2,  40'h7F_00_00_00_00, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    set_vec(3,  40'h7F_00_00_00_00, 1, 1'b0, 32'h0000_007F, 1'b0);
`ifdef LEB128_DEC_OVERFLOW_CHK_EN
    set_vec(4,  40'hFF_FF_FF_FF_1F, 5, 1'b0, 32'h0000_0000, 1'b1);
`else
    set_vec(4,  40'hFF_FF_FF_FF_1F, 5, 1'b0, 32'hFFFF_FFFF, 1'b0);
`endif
    set_vec(5,  40'hFF_FF_FF_FF_0F, 5, 1'b0, 32'hFFFF_FFFF, 1'b0);
    set_vec(6,  40'h80_7F_00_00_00, 2, 1'b1, 32'hFFFF_FF80, 1'b0);
    set_vec(7,  40'h00_00_00_00_00, 1, 1'b0, 32'h0000_0000, 1'b0);
    set_vec(8,  40'hFF_FF_FF_FF_7F, 5, 1'b1, 32'hFFFF_FFFF, 1'b0);
    set_vec(9,  40'h80_80_80_80_78, 5, 1'b1, 32'h8000_0000, 1'b0);
    set_vec(10, 40'h80_80_01_00_00, 3, 1'b0, 32'h0000_4000, 1'b0);
    set_vec(11, 40'h3F_00_00_00_00, 1, 1'b1, 32'h0000_003F, 1'b0);

    rst_n         = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_state",     32'(dbg_state),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table vectors, back-to-back; result must be valid right after the last byte
    foreach (tbl[k]) begin
      exp_q.push_back({tbl[k].e, tbl[k].d});
      send_seq(tbl[k].b, tbl[k].n, tbl[k].sgn);
      chk($sformatf("latency_v%0d", k), 32'(bus.out_valid), 32'd1);
    end

    // Random values through the reference encoder
    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      rv = $urandom >> $urandom_range(0, 31);
      if (rs && $urandom_range(0, 1) == 1) rv = -rv;
      rn = encode(rv, rs, rb);
      exp_q.push_back({1'b0, rv});
      send_seq(rb, rn, rs);
    end

    // Backpressure: result held, input stalled, then bypass accept
    idle(2);
    bus.out_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_002A});
    send_byte(8'h2A, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data",  bus.out_data,       32'h0000_002A);
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0005});
    send_byte(8'h05, 1'b0);
    chk("bypass_data", bus.out_data, 32'h0000_0005);

    // Overlong with a drained tail, then a good value
    ob = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    exp_q.push_back({1'b1, 32'd0});
    send_seq(ob, 5, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({1'b0, 32'h0000_0002});
    send_byte(8'h02, 1'b0);

    // Overlong where the drain terminator arrives with the error handshake
    exp_q.push_back({1'b1, 32'd0});
    send_seq(ob, 5, 1'b1);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({1'b0, 32'h0000_0007});
    send_byte(8'h07, 1'b0);

    // Reset mid-emit: result is lost, out_valid drops at once
    idle(3);
    bus.out_ready = 1'b0;
    send_byte(8'h11, 1'b0);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_emit_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-value: partial bytes discarded
    send_byte(8'h80, 1'b0);
    send_byte(8'h80, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_state", 32'(dbg_state),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0003});
    send_byte(8'h03, 1'b0);

    // Drain the scoreboard
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
